// File: rtl/alu_src_ctrl.sv
// Multicycle control FSM for the shared-ALU datapath: sequences operand muxes,
// ALU op, PC/IR/memory/register-file enables. All outputs are registered decodes.
module alu_src_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       excp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_EXCP     = 4'd12
  } state_t;

  localparam logic [2:0] LP_WAIT  = 3'(MEM_WAIT);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic       w_funct_ok, w_funct_arith;

  logic       w_alu_src_a, w_pc_write, w_pc_write_cond, w_iord, w_mem_write;
  logic       w_ir_write, w_reg_write, w_reg_dst, w_mem_to_reg, w_excp;
  logic [1:0] w_alu_src_b, w_pc_source;
  logic [2:0] w_alu_op;

  // The branch zero flag gates PCWriteCond in the datapath, not here.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  always_comb begin
    w_funct_ok    = funct inside {FN_ADD, FN_SUB, FN_AND};
    w_funct_arith = funct inside {FN_ADD, FN_SUB};
    w_next        = r_state;
    w_cnt_next    = '0;
    case (r_state)
      S_FETCH:
        if (r_cnt == LP_WAIT) w_next = S_DECODE;
        else                  w_cnt_next = r_cnt + 3'd1;
      S_DECODE:
        case (opcode)
          OP_RTYPE:     w_next = w_funct_ok ? S_EXEC_R : S_EXCP;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_EXCP;
        endcase
      S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (r_cnt == LP_WAIT) w_next = S_MEM_WB;
        else                  w_cnt_next = r_cnt + 3'd1;
      S_MEM_WR:
        if (r_cnt == LP_WAIT) w_next = S_FETCH;
        else                  w_cnt_next = r_cnt + 3'd1;
      S_EXEC_R: w_next = (overflow && w_funct_arith) ? S_EXCP : S_WB_R;
      S_EXEC_I: w_next = overflow ? S_EXCP : S_WB_I;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs decode the upcoming state so the registered copies line up with it.
  always_comb begin
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 3'b000;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 2'b00;
    w_iord          = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_excp          = 1'b0;
    case (w_next)
      S_FETCH: begin
        w_alu_src_b = 2'b01;
        w_alu_op    = ALU_ADD;
        w_ir_write  = (w_cnt_next == LP_WAIT);
        w_pc_write  = (w_cnt_next == LP_WAIT);
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = ALU_ADD;
      end
      S_MEM_RD: w_iord = 1'b1;
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = (funct == FN_SUB) ? ALU_SUB :
                      (funct == FN_AND) ? ALU_AND : ALU_ADD;
      end
      S_WB_R: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_WB_I: w_reg_write = 1'b1;
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
      S_EXCP: w_excp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_cnt       <= '0;
      AluSrcA     <= 1'b0;
      AluSrcB     <= '0;
      AluOp       <= '0;
      PCWrite     <= 1'b0;
      PCWriteCond <= 1'b0;
      PCSource    <= '0;
      IorD        <= 1'b0;
      MemWrite    <= 1'b0;
      IRWrite     <= 1'b0;
      RegWrite    <= 1'b0;
      RegDst      <= 1'b0;
      MemToReg    <= 1'b0;
      excp        <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      AluSrcA     <= w_alu_src_a;
      AluSrcB     <= w_alu_src_b;
      AluOp       <= w_alu_op;
      PCWrite     <= w_pc_write;
      PCWriteCond <= w_pc_write_cond;
      PCSource    <= w_pc_source;
      IorD        <= w_iord;
      MemWrite    <= w_mem_write;
      IRWrite     <= w_ir_write;
      RegWrite    <= w_reg_write;
      RegDst      <= w_reg_dst;
      MemToReg    <= w_mem_to_reg;
      excp        <= w_excp;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_alu_src_ctrl.sv
// Bench for alu_src_ctrl: per-instruction phase lists built from the state rules,
// compared cycle by cycle against the DUT under randomized instruction streams.
module tb_alu_src_ctrl;
  localparam int MW = 2;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_RD = 3,
                 ST_MEM_WB = 4, ST_MEM_WR = 5, ST_EXEC_R = 6, ST_WB_R = 7,
                 ST_EXEC_I = 8, ST_WB_I = 9, ST_BRANCH = 10, ST_JUMP = 11,
                 ST_EXCP = 12;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, overflow = 1'b0;
  logic       AluSrcA, PCWrite, PCWriteCond, IorD, MemWrite, IRWrite;
  logic       RegWrite, RegDst, MemToReg, excp;
  logic [1:0] AluSrcB, PCSource;
  logic [2:0] AluOp;
  logic [3:0] state;
  logic [20:0] dut_vec;

  int n_cmp = 0, n_bad = 0;
  int tot_iord = 0, tot_memw = 0, tot_regw = 0, tot_excp = 0, tot_pcw = 0, tot_irw = 0;
  int s_iord, s_memw, s_regw, s_excp, s_pcw, s_irw;
  int phase_q[$];
  bit zf = 1'b0;

  always #5 clk = ~clk;

  alu_src_ctrl #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .excp(excp), .state(state)
  );

  assign dut_vec = {state, AluSrcA, AluSrcB, AluOp, PCWrite, PCWriteCond, PCSource,
                    IorD, MemWrite, IRWrite, RegWrite, RegDst, MemToReg, excp};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [20:0] pack_vec(input int st, input bit last, input logic [5:0] fn);
    logic a = 0, pcw = 0, pcwc = 0, iord = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0, ex = 0;
    logic [1:0] b = 0, pcs = 0;
    logic [2:0] op = 0;
    case (st)
      ST_FETCH:    begin b = 2'b01; op = 3'b001; irw = last; pcw = last; end
      ST_DECODE:   begin b = 2'b11; op = 3'b001; end
      ST_MEM_ADDR: begin a = 1; b = 2'b10; op = 3'b001; end
      ST_MEM_RD:   iord = 1;
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin iord = 1; mw = 1; end
      ST_EXEC_R:   begin a = 1; op = (fn == FN_SUB) ? 3'b010 : (fn == FN_AND) ? 3'b011 : 3'b001; end
      ST_WB_R:     begin rd = 1; rw = 1; end
      ST_EXEC_I:   begin a = 1; b = 2'b10; op = 3'b001; end
      ST_WB_I:     rw = 1;
      ST_BRANCH:   begin a = 1; op = 3'b010; pcwc = 1; pcs = 2'b01; end
      ST_JUMP:     begin pcw = 1; pcs = 2'b10; end
      ST_EXCP:     ex = 1;
      default: ;
    endcase
    return {st[3:0], a, b, op, pcw, pcwc, pcs, iord, mw, irw, rw, rd, m2r, ex};
  endfunction

  task automatic build_phases(input logic [5:0] op, input logic [5:0] fn, input bit ovf);
    phase_q.delete();
    for (int i = 0; i <= MW; i++) phase_q.push_back(ST_FETCH);
    phase_q.push_back(ST_DECODE);
    if (op == OP_R && (fn == FN_ADD || fn == FN_SUB || fn == FN_AND)) begin
      phase_q.push_back(ST_EXEC_R);
      phase_q.push_back((ovf && fn != FN_AND) ? ST_EXCP : ST_WB_R);
    end else if (op == OP_ADDI) begin
      phase_q.push_back(ST_EXEC_I);
      phase_q.push_back(ovf ? ST_EXCP : ST_WB_I);
    end else if (op == OP_LW || op == OP_SW) begin
      phase_q.push_back(ST_MEM_ADDR);
      for (int i = 0; i <= MW; i++) phase_q.push_back(op == OP_LW ? ST_MEM_RD : ST_MEM_WR);
      if (op == OP_LW) phase_q.push_back(ST_MEM_WB);
    end else if (op == OP_BEQ) phase_q.push_back(ST_BRANCH);
    else if (op == OP_J) phase_q.push_back(ST_JUMP);
    else phase_q.push_back(ST_EXCP);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One clock: drive inputs just after the edge, compare all outputs mid-cycle.
  task automatic drive_cycle(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                             input logic rst, input logic [20:0] ev, input string tag);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; funct = fn; overflow = ov; zero = 1'($urandom);
    @(negedge clk);
    check({"ctl ", tag}, 32'(dut_vec), 32'(ev));
    check({"pcw_excl ", tag}, 32'(PCWrite & PCWriteCond), 32'd0);
    check({"wr_excl ", tag}, 32'(RegWrite & MemWrite), 32'd0);
    tot_iord += int'(IorD); tot_memw += int'(MemWrite); tot_regw += int'(RegWrite);
    tot_excp += int'(excp); tot_pcw += int'(PCWrite); tot_irw += int'(IRWrite);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit ovf,
                           input int abort_sel);
    int n, abort_at, st;
    logic [20:0] ev;
    build_phases(op, fn, ovf);
    n = phase_q.size();
    abort_at = (abort_sel < 0) ? -1 : abort_sel % n;
    for (int i = 0; i < n; i++) begin
      st = phase_q[i];
      ev = (zf && i == 0) ? '0 : pack_vec(st, (st == ST_FETCH) && (i == MW), fn);
      drive_cycle(st == ST_FETCH ? 6'($urandom) : op, st == ST_FETCH ? 6'($urandom) : fn,
                  (st == ST_EXEC_R || st == ST_EXEC_I) ? ovf : 1'($urandom),
                  (i == abort_at) ? 1'b0 : 1'b1, ev,
                  $sformatf("op=%b fn=%b ph%0d", op, fn, i));
      if (i == abort_at) begin
        repeat (2) drive_cycle(6'($urandom), 6'($urandom), 1'($urandom), 1'b0, '0, "in_reset");
        zf = 1'b1;
        return;
      end
    end
    zf = 1'b0;
  endtask

  task automatic snap();
    s_iord = tot_iord; s_memw = tot_memw; s_regw = tot_regw;
    s_excp = tot_excp; s_pcw = tot_pcw; s_irw = tot_irw;
  endtask

  initial begin
    reset = 1'b0;
    @(posedge clk);
    repeat (2) drive_cycle('0, '0, 1'b0, 1'b0, '0, "reset_state");
    zf = 1'b1;

    // lw aborted by a 3-cycle reset in its first MEM_RD cycle, then a sub
    run_instr(OP_LW, '0, 1'b0, 3 + MW);
    snap();
    run_instr(OP_R, FN_SUB, 1'b0, -1);
    check("len_sub", 32'(phase_q.size()), 32'd6);
    check("sub_irw", 32'(tot_irw - s_irw), 32'd1);
    check("sub_regw", 32'(tot_regw - s_regw), 32'd1);

    snap();
    run_instr(OP_LW, '0, 1'b0, -1);
    check("len_lw", 32'(phase_q.size()), 32'd9);
    check("lw_iord", 32'(tot_iord - s_iord), 32'd3);
    check("lw_regw", 32'(tot_regw - s_regw), 32'd1);

    snap();
    run_instr(OP_SW, '0, 1'b0, -1);
    check("len_sw", 32'(phase_q.size()), 32'd8);
    check("sw_memw", 32'(tot_memw - s_memw), 32'd3);
    check("sw_regw", 32'(tot_regw - s_regw), 32'd0);

    run_instr(OP_BEQ, '0, 1'b0, -1);
    check("len_beq", 32'(phase_q.size()), 32'd5);
    run_instr(OP_J, '0, 1'b0, -1);
    check("len_j", 32'(phase_q.size()), 32'd5);

    snap();
    run_instr(OP_ADDI, '0, 1'b1, -1);
    check("addi_ovf_excp", 32'(tot_excp - s_excp), 32'd1);
    check("addi_ovf_regw", 32'(tot_regw - s_regw), 32'd0);

    snap();
    run_instr(6'b111111, '0, 1'b0, -1);
    run_instr(OP_R, 6'b000111, 1'b0, -1);
    check("illegal_excp", 32'(tot_excp - s_excp), 32'd2);
    check("illegal_pcw", 32'(tot_pcw - s_pcw), 32'd2);
    check("illegal_memw", 32'(tot_memw - s_memw), 32'd0);
    check("illegal_regw", 32'(tot_regw - s_regw), 32'd0);

    snap();
    run_instr(OP_R, FN_ADD, 1'b1, -1);
    run_instr(OP_R, FN_AND, 1'b1, -1);
    check("r_ovf_excp", 32'(tot_excp - s_excp), 32'd1);
    check("r_ovf_regw", 32'(tot_regw - s_regw), 32'd1);

    for (int k = 0; k < 250; k++) begin
      logic [5:0] op, fn;
      int sel;
      sel = int'($urandom_range(0, 9));
      fn = 6'($urandom);
      case (sel)
        0: begin op = OP_R; fn = FN_ADD; end
        1: begin op = OP_R; fn = FN_SUB; end
        2: begin op = OP_R; fn = FN_AND; end
        3: op = OP_R;
        4: op = OP_ADDI;
        5: op = OP_LW;
        6: op = OP_SW;
        7: op = OP_BEQ;
        8: op = OP_J;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, $urandom_range(0, 3) == 0,
                ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 20)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_src_ctrl.md
Name: alu_src_ctrl

Overview:
- Multicycle control FSM that sequences the shared ALU and its operand multiplexers (AluSrcA, the 4-way AluSrcB select) plus PC, IR, memory and register-file enables.
- Covers the core integer subset: R-type add/sub/and, addi, lw, sw, beq, j.
- Sits between the instruction register and the datapath; one instruction in flight at a time.

Parameters:
- MEM_WAIT, 2, extra cycles memory needs after the address is presented before read data/write completion is valid (0..7).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag
- overflow  input  1  ALU signed overflow flag, valid in execute states
- AluSrcA  output  1  0=PC, 1=reg A
- AluSrcB  output  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
- AluOp  output  3  001=add, 010=sub, 011=and, 000=nop
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if zero
- PCSource  output  2  00=ALU result, 01=ALUOut reg, 10=jump target
- IorD  output  1  0=PC addresses memory, 1=ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load
- RegWrite  output  1  register-file write
- RegDst  output  1  0=rt, 1=rd
- MemToReg  output  1  0=ALUOut, 1=MDR
- excp  output  1  one-cycle pulse: illegal opcode/funct or arithmetic overflow
- state  output  4  current state encoding, for debug

Behaviour:
- All outputs are registered Moore decodes of state. reset low at a clk edge -> state=FETCH, wait counter=0, every output 0 on the following cycle. Reset mid-instruction aborts it; no partial write survives because write strobes are decoded from state.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11, EXCP=12.
- FETCH:
  - IorD=0, AluSrcA=0, AluSrcB=01, AluOp=add, PCSource=00.
  - IRWrite and PCWrite assert only on the last cycle, after MEM_WAIT wait cycles. With MEM_WAIT=0, FETCH lasts one cycle.
  - Then go to DECODE.
- DECODE (1 cycle): AluSrcA=0, AluSrcB=11, AluOp=add to precompute the branch target. Dispatch on opcode:
  - 000000 with funct 100000/100010/100100 -> EXEC_R
  - 001000 -> EXEC_I
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - anything else, including an unlisted funct -> EXCP
- MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOp=add. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1. Held for 1+MEM_WAIT cycles, then MEM_WB.
- MEM_WB: RegDst=0, MemToReg=1, RegWrite=1. Then FETCH.
- MEM_WR: IorD=1, MemWrite=1. Held 1+MEM_WAIT cycles, then FETCH.
- EXEC_R: AluSrcA=1, AluSrcB=00, AluOp from funct (100000 add, 100010 sub, 100100 and).
  - If overflow on add/sub -> EXCP; no RegWrite.
  - Otherwise WB_R.
- WB_R: RegDst=1, MemToReg=0, RegWrite=1. Then FETCH.
- EXEC_I: AluSrcA=1, AluSrcB=10, AluOp=add. overflow -> EXCP, else WB_I.
- WB_I: RegDst=0, MemToReg=0, RegWrite=1. Then FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=sub, PCWriteCond=1, PCSource=01. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- EXCP: excp=1 for exactly one cycle, no write strobes. Then FETCH.
- Wait counter: 3 bits. Cleared on entry to each wait-capable state; counts up while in it; exit when counter==MEM_WAIT.
- Cycle counts at MEM_WAIT=2:
  - add: 3+1+1+1 = 6
  - lw: 3+1+1+3+1 = 9
  - sw: 8
  - beq: 5
  - j: 5
- Only one of PCWrite/PCWriteCond, and at most one of RegWrite/MemWrite, may be high in any cycle.

Test Plan:
- Reset held low 3 cycles during MEM_RD, then released -> next cycle state=0, all strobes 0; after MEM_WAIT=2, IRWrite=PCWrite=1 for exactly one cycle with AluSrcB=01.
- opcode=000000, funct=100010, overflow=0 -> EXEC_R shows AluSrcB=00, AluOp=010; WB_R shows RegWrite=1, RegDst=1; 6 cycles total.
- opcode=100011 (lw) with MEM_WAIT=2 -> MEM_ADDR shows AluSrcB=10; IorD=1 for 3 cycles; MEM_WB shows RegWrite=1, MemToReg=1; back in FETCH at cycle 9.
- opcode=000100, zero=1 -> DECODE AluSrcB=11; BRANCH PCWriteCond=1, PCSource=01, AluOp=010; sw run -> MemWrite high 3 cycles, RegWrite never high.
- opcode=001000 with overflow=1 in EXEC_I -> excp pulses 1 cycle, RegWrite stays 0, FETCH follows.
- opcode=111111, and separately funct=000111 with R-type -> DECODE->EXCP, excp one cycle, no PC/memory/register write.
